// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the tx-path stream arbiter: well-known source indices
// and the arbiter state encoding.
package stream_arbiter_pkg;

    localparam int STRM_ID_RESP   = 0;
    localparam int STRM_ID_SAMPLE = 1;
    localparam int STRM_ID_DEBUG  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_arb_pick.sv
// Combinational winner picker: fixed priority (index 0 highest) or round-robin
// starting at rr_ptr and searching upward with wrap-around.
module stream_arb_pick
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_STREAMS = 2,
    parameter int RR_MODE     = 0,
    parameter int IDX_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic [NUM_STREAMS-1:0] avail,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (RR_MODE != 0) begin
                idx = IDX_W'((int'(rr_ptr) + k) % NUM_STREAMS);
            end else begin
                idx = IDX_W'(k);
            end
            if (!valid && avail[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// N-input message arbiter: grants one source for a whole message and merges it
// into a single byte stream for the tx framer.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_STREAMS = 2,
    parameter int DATA_W      = 8,
    parameter int COUNT_W     = 10,
    parameter int ID_W        = 4,
    parameter int RR_MODE     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_STREAMS*DATA_W-1:0]  in_data,
    input  logic [NUM_STREAMS*COUNT_W-1:0] in_count,
    input  logic [NUM_STREAMS-1:0]         in_avail,
    output logic [NUM_STREAMS-1:0]         in_pull,
    output logic [DATA_W-1:0]              strm_data,
    output logic [COUNT_W-1:0]             strm_count,
    output logic [ID_W-1:0]                strm_id,
    output logic                           strm_avail,
    input  logic                           strm_pull
);

    localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant, rr_ptr, pick_idx;
    logic               pick_vld;
    logic [COUNT_W-1:0] remaining, count_q, head_count;
    logic               active;

    stream_arb_pick #(
        .NUM_STREAMS (NUM_STREAMS),
        .RR_MODE     (RR_MODE),
        .IDX_W       (IDX_W)
    ) u_pick (
        .avail  (in_avail),
        .rr_ptr (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign head_count = in_count[pick_idx*COUNT_W +: COUNT_W];
    assign active     = (state == OFFER) || (state == SEND);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pick_vld) state_nxt = OFFER;
            OFFER: begin
                if (strm_pull) begin
                    state_nxt = (remaining == COUNT_W'(1)) ? DONE : SEND;
                end else if (!in_avail[grant]) begin
                    state_nxt = IDLE;
                end
            end
            SEND:  if (strm_pull && remaining == COUNT_W'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length message still needs one pull so the source pops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            count_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant     <= pick_idx;
                        count_q   <= head_count;
                        remaining <= (head_count == '0) ? COUNT_W'(1) : head_count;
                    end
                end
                OFFER, SEND: begin
                    if (strm_pull) remaining <= remaining - COUNT_W'(1);
                end
                DONE: begin
                    if (RR_MODE != 0) begin
                        rr_ptr <= (grant == IDX_W'(NUM_STREAMS - 1)) ? '0 : grant + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_pull = '0;
        if (active && strm_pull) in_pull[grant] = 1'b1;
        strm_data = active ? in_data[grant*DATA_W +: DATA_W] : '0;
        strm_id   = '0;
        strm_id[IDX_W-1:0] = grant;
    end

    assign strm_avail = active;
    assign strm_count = count_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench: a two-stream fixed-priority arbiter and a four-stream
// round-robin arbiter driven by a vector table plus hand-written sequences.
module tb_stream_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // two-stream fixed-priority instance
    logic [15:0] in_data2;
    logic [19:0] in_count2;
    logic [1:0]  in_avail2, in_pull2;
    logic [7:0]  strm_data2;
    logic [9:0]  strm_count2;
    logic [3:0]  strm_id2;
    logic        strm_avail2, strm_pull2;

    // four-stream round-robin instance
    logic [31:0] in_data4;
    logic [39:0] in_count4;
    logic [3:0]  in_avail4, in_pull4;
    logic [7:0]  strm_data4;
    logic [9:0]  strm_count4;
    logic [3:0]  strm_id4;
    logic        strm_avail4, strm_pull4;

    stream_arbiter #(.NUM_STREAMS(2), .DATA_W(8), .COUNT_W(10), .ID_W(4), .RR_MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_count(in_count2),
        .in_avail(in_avail2), .in_pull(in_pull2), .strm_data(strm_data2),
        .strm_count(strm_count2), .strm_id(strm_id2), .strm_avail(strm_avail2),
        .strm_pull(strm_pull2)
    );

    stream_arbiter #(.NUM_STREAMS(4), .DATA_W(8), .COUNT_W(10), .ID_W(4), .RR_MODE(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_count(in_count4),
        .in_avail(in_avail4), .in_pull(in_pull4), .strm_data(strm_data4),
        .strm_count(strm_count4), .strm_id(strm_id4), .strm_avail(strm_avail4),
        .strm_pull(strm_pull4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] avail;
        logic [9:0] c0, c1;
        logic [7:0] d0, d1;
        logic       pull;
        logic       e_avail;
        logic [3:0] e_id;
        logic [9:0] e_cnt;
        logic [7:0] e_data;
        logic [1:0] e_pull;
    } vec_t;

    vec_t tbl[18];
    int   exp_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        int g;
        // single message from stream 1, then stream 1 (count 4) vs late stream 0
        tbl[0]  = '{2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[1]  = '{2'b10, 10'd0, 10'd3, 8'h00, 8'hA1, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[2]  = '{2'b10, 10'd0, 10'd3, 8'h00, 8'hA1, 1'b1, 1'b1, 4'd1, 10'd3, 8'hA1, 2'b10};
        tbl[3]  = '{2'b10, 10'd0, 10'd3, 8'h00, 8'hA2, 1'b1, 1'b1, 4'd1, 10'd3, 8'hA2, 2'b10};
        tbl[4]  = '{2'b10, 10'd0, 10'd3, 8'h00, 8'hA3, 1'b1, 1'b1, 4'd1, 10'd3, 8'hA3, 2'b10};
        tbl[5]  = '{2'b00, 10'd0, 10'd3, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[6]  = '{2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[7]  = '{2'b10, 10'd0, 10'd4, 8'h00, 8'hB1, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[8]  = '{2'b10, 10'd0, 10'd4, 8'h00, 8'hB1, 1'b1, 1'b1, 4'd1, 10'd4, 8'hB1, 2'b10};
        tbl[9]  = '{2'b10, 10'd0, 10'd9, 8'h00, 8'hB2, 1'b1, 1'b1, 4'd1, 10'd4, 8'hB2, 2'b10};
        tbl[10] = '{2'b11, 10'd2, 10'd9, 8'hC1, 8'hB3, 1'b1, 1'b1, 4'd1, 10'd4, 8'hB3, 2'b10};
        tbl[11] = '{2'b11, 10'd2, 10'd9, 8'hC1, 8'hB4, 1'b1, 1'b1, 4'd1, 10'd4, 8'hB4, 2'b10};
        tbl[12] = '{2'b01, 10'd2, 10'd0, 8'hC1, 8'h00, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[13] = '{2'b01, 10'd2, 10'd0, 8'hC1, 8'h00, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};
        tbl[14] = '{2'b01, 10'd2, 10'd0, 8'hC1, 8'h00, 1'b0, 1'b1, 4'd0, 10'd2, 8'hC1, 2'b00};
        tbl[15] = '{2'b01, 10'd2, 10'd0, 8'hC1, 8'h00, 1'b1, 1'b1, 4'd0, 10'd2, 8'hC1, 2'b01};
        tbl[16] = '{2'b01, 10'd2, 10'd0, 8'hC2, 8'h00, 1'b1, 1'b1, 4'd0, 10'd2, 8'hC2, 2'b01};
        tbl[17] = '{2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 10'd0, 8'h00, 2'b00};

        in_data2 = '0; in_count2 = '0; in_avail2 = '0; strm_pull2 = 1'b0;
        in_data4 = {8'h33, 8'h22, 8'h11, 8'h00};
        in_count4 = {4{10'd1}}; in_avail4 = '0; strm_pull4 = 1'b0;

        // reset state
        #12;
        check("rst_avail", 32'(strm_avail2), 32'd0);
        check("rst_count", 32'(strm_count2), 32'd0);
        check("rst_id", 32'(strm_id2), 32'd0);
        check("rst_data", 32'(strm_data2), 32'd0);
        check("rst_pull", 32'(in_pull2), 32'd0);
        check("rst_avail4", 32'(strm_avail4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_avail2  = tbl[i].avail;
            in_count2  = {tbl[i].c1, tbl[i].c0};
            in_data2   = {tbl[i].d1, tbl[i].d0};
            strm_pull2 = tbl[i].pull;
            #1;
            check($sformatf("v%0d_avail", i), 32'(strm_avail2), 32'(tbl[i].e_avail));
            check($sformatf("v%0d_data", i), 32'(strm_data2), 32'(tbl[i].e_data));
            check($sformatf("v%0d_in_pull", i), 32'(in_pull2), 32'(tbl[i].e_pull));
            if (tbl[i].e_avail) begin
                check($sformatf("v%0d_id", i), 32'(strm_id2), 32'(tbl[i].e_id));
                check($sformatf("v%0d_count", i), 32'(strm_count2), 32'(tbl[i].e_cnt));
            end
        end

        // zero-length message on stream 0
        @(negedge clk);
        in_avail2 = 2'b01; in_count2 = '0; in_data2 = {8'h00, 8'h5A}; strm_pull2 = 1'b0;
        #1 check("z_idle", 32'(strm_avail2), 32'd0);
        @(negedge clk); #1;
        check("z_avail", 32'(strm_avail2), 32'd1);
        check("z_count", 32'(strm_count2), 32'd0);
        check("z_id", 32'(strm_id2), 32'd0);
        strm_pull2 = 1'b1; #1;
        check("z_pull", 32'(in_pull2), 32'b01);
        check("z_data", 32'(strm_data2), 32'h5A);
        @(negedge clk);
        in_avail2 = 2'b00; strm_pull2 = 1'b0; #1;
        check("z_done_avail", 32'(strm_avail2), 32'd0);
        check("z_done_pull", 32'(in_pull2), 32'd0);
        @(negedge clk); #1;
        check("z_back_idle", 32'(strm_avail2), 32'd0);

        // asynchronous reset in the middle of an 8-byte message
        @(negedge clk);
        in_avail2 = 2'b01; in_count2 = {10'd0, 10'd8}; in_data2 = {8'h00, 8'h77};
        @(negedge clk); #1;
        check("r_offer", 32'(strm_avail2), 32'd1);
        check("r_count", 32'(strm_count2), 32'd8);
        strm_pull2 = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("r_avail", 32'(strm_avail2), 32'd0);
        check("r_count0", 32'(strm_count2), 32'd0);
        check("r_pull", 32'(in_pull2), 32'd0);
        check("r_data", 32'(strm_data2), 32'd0);
        @(negedge clk);
        in_avail2 = 2'b00; strm_pull2 = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("r_stay_idle", 32'(strm_avail2), 32'd0);
        end

        // round-robin fairness: all four streams always pending, count 1 each
        in_avail4 = 4'b1111;
        g = 0;
        for (int c = 0; c < 40 && g < 5; c++) begin
            @(negedge clk);
            strm_pull4 = 1'b0;
            #1;
            if (strm_avail4) begin
                check($sformatf("rr%0d_id", g), 32'(strm_id4), 32'(exp_seq[g]));
                check($sformatf("rr%0d_data", g), 32'(strm_data4), 32'(exp_seq[g] * 8'h11));
                strm_pull4 = 1'b1; #1;
                check($sformatf("rr%0d_pull", g), 32'(in_pull4), 32'(4'b0001 << exp_seq[g]));
                g++;
            end
        end
        check("rr_grants_seen", 32'(g), 32'd5);

        // withdraw on a round-robin instance: rr_ptr must not move
        @(negedge clk);
        in_avail4 = 4'b0000; strm_pull4 = 1'b0;
        @(negedge clk);
        in_avail4 = 4'b0010;
        @(negedge clk); #1;
        check("w_offer", 32'(strm_avail4), 32'd1);
        check("w_id", 32'(strm_id4), 32'd1);
        in_avail4 = 4'b0000; #1;
        check("w_no_pull", 32'(in_pull4), 32'd0);
        @(negedge clk); #1;
        check("w_withdrawn", 32'(strm_avail4), 32'd0);
        check("w_no_pull2", 32'(in_pull4), 32'd0);
        in_avail4 = 4'b1111;
        @(negedge clk); #1;
        check("w_rr_kept", 32'(strm_id4), 32'd1);
        strm_pull4 = 1'b1; #1;
        check("w_final_pull", 32'(in_pull4), 32'b0010);
        @(negedge clk);
        strm_pull4 = 1'b0; in_avail4 = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Parametrised N-input message arbiter for the tx path. Selects one pending message stream and offers it to the tx framer as a single merged stream.
- Holds the grant for a whole message, i.e. until `count` bytes have been pulled. The downstream framer therefore never supplies a send id back.
- Supports fixed-priority and round-robin modes.
- Sits between the per-source message queues (response, sample, future debug/log streams) and the tx framer.

Parameters:
- NUM_STREAMS, 2: number of input streams; legal range 2..16.
- DATA_W, 8: byte width of data.
- COUNT_W, 10: message length width.
- ID_W, 4: width of strm_id; must satisfy 2**ID_W >= NUM_STREAMS.
- RR_MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  NUM_STREAMS*DATA_W  per-stream current byte; stream i occupies bits [i*DATA_W +: DATA_W].
- in_count  in  NUM_STREAMS*COUNT_W  per-stream message length of the head message.
- in_avail  in  NUM_STREAMS  per-stream message-pending flag.
- in_pull  out  NUM_STREAMS  per-stream byte-consume strobe.
- strm_data  out  DATA_W  byte of the granted stream.
- strm_count  out  COUNT_W  latched length of the offered message.
- strm_id  out  ID_W  granted stream index, zero-extended.
- strm_avail  out  1  message offered.
- strm_pull  in  1  downstream consumes one byte.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low. Reset takes effect immediately and releases synchronously to clk.
- Reset values:
  - state = IDLE, grant = 0, rr_ptr = 0, remaining = 0.
  - strm_avail = 0, strm_count = 0, strm_id = 0, strm_data = 0, in_pull = 0.
- States:
  - IDLE: no grant. If any in_avail is set, pick the winner, register grant, strm_count = in_count[winner] and remaining = max(in_count[winner], 1), then go to OFFER. Otherwise stay in IDLE.
  - OFFER: strm_avail = 1. strm_id and strm_count come from registers.
    - On strm_pull: decrement remaining and go to SEND. If remaining was 1, go to DONE instead.
    - If in_avail[grant] drops with no pull: withdraw and go to IDLE; rr_ptr is unchanged.
  - SEND: strm_avail = 1. Each strm_pull decrements remaining. The pull that takes remaining from 1 to 0 moves the state to DONE.
  - DONE: strm_avail = 0, in_pull = 0. Unconditionally go to IDLE next cycle. In RR_MODE, rr_ptr = (grant+1) mod NUM_STREAMS.
    - This bubble exists so the finished source can deassert in_avail before the next arbitration.
- Arbitration:
  - Fixed mode: lowest-index in_avail wins.
  - RR mode: first set in_avail at or after rr_ptr, searching upward with wrap-around.
  - Computed combinationally from in_avail. Registered only in IDLE.
- Pull path (combinational, no added latency):
  - in_pull[i] = strm_pull && state in {OFFER, SEND} && grant == i.
  - strm_data = in_data[grant] when state in {OFFER, SEND}, else 0. The source presents the byte in the same cycle it is pulled.
  - strm_pull while strm_avail = 0 is ignored and not forwarded.
- Length rules:
  - count = 0 is a legal zero-length message. It is offered with strm_count = 0 and completes after exactly one pull, which is forwarded so the source pops it.
  - All other messages complete after exactly count pulls.
- Latency:
  - in_avail rise in IDLE to strm_avail = 1: 1 cycle.
  - Last pull to next strm_avail: 3 cycles (DONE, IDLE, OFFER).
- Stability: a message in progress is never pre-empted, even by a higher-priority stream. in_count changes after latching do not affect strm_count or remaining.
- Mid-message reset: all outputs go to their reset values immediately, and no further in_pull is issued. Recovering the source is the source's responsibility.

Decomposition:
- Shared package holds:
  - the stream index constants (STRM_ID_RESP = 0, STRM_ID_SAMPLE = 1, STRM_ID_DEBUG = 2);
  - the state encoding (IDLE, OFFER, SEND, DONE).
- One sub-module, stream_arb_pick: combinational priority/round-robin picker taking in_avail and rr_ptr and returning the winner index plus a valid flag. It is parametrised by NUM_STREAMS and RR_MODE and unit-testable on its own.

Test Plan:
- Reset and single message: NUM_STREAMS=2, stream 1 avail with count=3, bytes A1,A2,A3, one pull per cycle.
  - strm_avail rises 1 cycle after avail; strm_id = 1, strm_count = 3.
  - strm_data shows A1, A2, A3; in_pull[1] pulses 3 times, in_pull[0] never.
  - strm_avail = 0 after the 3rd pull.
- Fixed priority with no pre-emption: stream 1 granted with count=4. Stream 0 raises avail after 2 pulls.
  - Stream 1 completes all 4 pulls.
  - Then stream 0 is offered 3 cycles after the last pull, with strm_id = 0.
- Round-robin fairness: NUM_STREAMS=4, RR_MODE=1, all avail, count=1 each, downstream pulls whenever strm_avail is set.
  - Grant sequence is 0,1,2,3,0.
- Zero-length message: stream 0 with count=0.
  - Offered with strm_count = 0. The single pull produces one in_pull[0] pulse, then the block returns to IDLE.
- Withdraw: stream 0 in OFFER drops in_avail before any pull.
  - strm_avail = 0 next cycle; no in_pull is issued; rr_ptr is unchanged.
- Async reset mid-SEND: assert rst_n low between clock edges while remaining = 5.
  - strm_avail, strm_count and in_pull are 0 immediately.
  - After release, with no avail, the block stays in IDLE.
